// File: rtl/bus_demux_1x8_buf.sv
// bus_demux_1x8_buf: routes one bus word into one of 8 single-entry holding slots
// with per-slot valid/ack handshake, flush, occupancy count and dropped-write flag.
module bus_demux_1x8_buf #(
   parameter int DATA_WIDTH = 6,
   parameter int SEL_WIDTH  = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [SEL_WIDTH-1:0]    in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [8*DATA_WIDTH-1:0] out_data,
   output logic [7:0]              out_valid,
   input  logic [7:0]              out_ack,
   output logic [3:0]              occupancy,
   output logic                    ovf_err
);
   logic [7:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [7:0]                 valid_q, valid_d;
   logic [3:0]                 occ_q, occ_d;
   logic                       ovf_q, ovf_d;
   logic                       accept;
   logic [7:0]                 wr_oh;
   assign in_ready = ~valid_q[in_sel] | out_ack[in_sel];
   assign accept   = in_valid & in_ready & ~flush;
   assign wr_oh    = accept ? 8'(1) << in_sel : 8'h00;
   always_comb begin
      data_d = data_q;
      if (accept) data_d[in_sel] = in_data;
      // a write on a slot being acked re-sets its valid, so write wins
      valid_d = flush ? 8'h00 : (valid_q & ~out_ack) | wr_oh;
      occ_d = '0;
      for (int k = 0; k < 8; k++) occ_d = occ_d + 4'(valid_d[k]);
      ovf_d = in_valid & ~in_ready & ~flush;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= '0;
         occ_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
         ovf_q   <= ovf_d;
      end
   end
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign occupancy = occ_q;
   assign ovf_err   = ovf_q;
endmodule

// File: tb/tb_bus_demux_1x8_buf.sv
// tb_bus_demux_1x8_buf: directed vector table plus hand sequences for fill, flush
// and asynchronous reset of the 1x8 buffered bus demux.
module tb_bus_demux_1x8_buf;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  in_data = '0;
   logic [2:0]  in_sel = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic [47:0] out_data;
   logic [7:0]  out_valid;
   logic [7:0]  out_ack = '0;
   logic [3:0]  occupancy;
   logic        ovf_err;
   int total = 0;
   int bad = 0;

   bus_demux_1x8_buf dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
      .out_ack(out_ack), .occupancy(occupancy), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [2:0] sel;
      logic [5:0] d;
      logic       fl;
      logic [7:0] ack;
      logic       rdy;
      logic [7:0] ev;
      logic [3:0] eo;
      logic       eovf;
      logic [5:0] eslot;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] slot(input int k);
      return out_data[k*6 +: 6];
   endfunction

   task automatic drive(input logic iv, input logic [2:0] sel, input logic [5:0] d,
                        input logic fl, input logic [7:0] ack);
      in_valid = iv; in_sel = sel; in_data = d; flush = fl; out_ack = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive(1'b0, in_sel, in_data, 1'b0, 8'h00);
   endtask

   initial begin
      vecs[0] = '{1, 3'd3, 6'h2A, 0, 8'h00, 1, 8'h08, 4'd1, 0, 6'h2A};
      vecs[1] = '{0, 3'd3, 6'h00, 0, 8'h08, 1, 8'h00, 4'd0, 0, 6'h2A};
      vecs[2] = '{1, 3'd5, 6'h11, 0, 8'h00, 1, 8'h20, 4'd1, 0, 6'h11};
      vecs[3] = '{1, 3'd5, 6'h22, 0, 8'h00, 0, 8'h20, 4'd1, 1, 6'h11};
      vecs[4] = '{0, 3'd5, 6'h00, 0, 8'h00, 0, 8'h20, 4'd1, 0, 6'h11};
      vecs[5] = '{1, 3'd5, 6'h33, 0, 8'h20, 1, 8'h20, 4'd1, 0, 6'h33};
      vecs[6] = '{0, 3'd7, 6'h00, 0, 8'h80, 1, 8'h20, 4'd1, 0, 6'h00};
      vecs[7] = '{1, 3'd0, 6'h15, 0, 8'h20, 1, 8'h01, 4'd1, 0, 6'h15};
      vecs[8] = '{1, 3'd0, 6'h3F, 1, 8'h00, 0, 8'h00, 4'd0, 0, 6'h15};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 64'(out_valid), 64'h00);
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_data", 64'(out_data), 64'd0);
      chk("reset_ovf", 64'(ovf_err), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].fl, vecs[i].ack);
         #1;
         chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
         tick();
         chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
         chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(vecs[i].eo));
         chk($sformatf("v%0d_ovf", i), 64'(ovf_err), 64'(vecs[i].eovf));
         chk($sformatf("v%0d_slot", i), 64'(slot(int'(vecs[i].sel))), 64'(vecs[i].eslot));
      end

      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 3'(k), 6'(8'h10 + k), 1'b0, 8'h00);
         tick();
         chk($sformatf("fill%0d_occ", k), 64'(occupancy), 64'(k + 1));
      end
      chk("fill_valid", 64'(out_valid), 64'hFF);
      for (int k = 0; k < 8; k++) chk($sformatf("fill_slot%0d", k), 64'(slot(k)), 64'(8'h10 + k));
      drive(1'b0, 3'd0, 6'h00, 1'b0, 8'hFF);
      tick();
      chk("drain_valid", 64'(out_valid), 64'h00);
      chk("drain_occ", 64'(occupancy), 64'd0);

      drive(1'b1, 3'd0, 6'h01, 1'b0, 8'h00);
      tick();
      drive(1'b1, 3'd2, 6'h02, 1'b0, 8'h00);
      tick();
      chk("pre_flush_valid", 64'(out_valid), 64'h05);
      chk("pre_flush_occ", 64'(occupancy), 64'd2);
      drive(1'b1, 3'd4, 6'h3E, 1'b1, 8'h01);
      tick();
      chk("flush_valid", 64'(out_valid), 64'h00);
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_slot4", 64'(slot(4)), 64'h14);
      chk("flush_slot0", 64'(slot(0)), 64'h01);
      chk("flush_ovf", 64'(ovf_err), 64'd0);

      drive(1'b1, 3'd1, 6'h2D, 1'b0, 8'h00);
      tick();
      chk("pre_rst_valid", 64'(out_valid), 64'h02);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'h00);
      chk("async_rst_occ", 64'(occupancy), 64'd0);
      chk("async_rst_data", 64'(out_data), 64'd0);
      #5;
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
